multi_usage_counter: RTL and testbench

Parametrised, multi-channel successor to the single-channel usage counter. Each channel counts qualifying activity on its observable input while `sample_enable` is high. Live counts are transferred into snapshot registers, either on a free-running measurement window or on software request, and read back through a registered mux. The block sits beside the CPU I/O space as a performance/duty monitor for arbitrary internal strobes.

---
 rtl/multi_usage_counter.sv | 144 ++++++++++++++
 tb/tb_multi_usage_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_usage_counter.sv
// Multi-channel activity/duty counter with windowed or manual snapshots and a registered readback mux.
// Optional build macro MULTI_USAGE_COUNTER_SATURATE_EN: live counters hold at all-ones instead of wrapping.
module multi_usage_counter #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 16,
    parameter int WINDOW_CYCLES = 0,
    parameter int COUNT_EDGES   = 0,
    parameter int SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                sysclk,
    input  logic                sysreset_n,
    input  logic [CHANNELS-1:0] observable_pulse,
    input  logic                sample_enable,
    input  logic                counter_reset,
    input  logic                snapshot,
    input  logic [SEL_W-1:0]    read_sel,
    output logic [WIDTH-1:0]    counter_out,
    output logic                snapshot_valid,
    output logic [CHANNELS-1:0] overflow
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cnt, input logic ev);
        logic [WIDTH-1:0] res;
        res = cnt;
        if (ev) begin
`ifdef MULTI_USAGE_COUNTER_SATURATE_EN
            if (cnt != {WIDTH{1'b1}})
                res = cnt + WIDTH'(1);
`else
            res = cnt + WIDTH'(1);
`endif
        end
        return res;
    endfunction

    logic [CHANNELS-1:0] ev_p0;
    logic                snap_ev_p0;
    logic [WIDTH-1:0]    live_nxt_p0 [CHANNELS];
    logic [WIDTH-1:0]    live_p1     [CHANNELS];
    logic [WIDTH-1:0]    snap_p1     [CHANNELS];
    logic [CHANNELS-1:0] ovf_p1;
    logic                vld_p1;
    logic [WIDTH-1:0]    sel_data_p1;
    logic [WIDTH-1:0]    cout_p2;

    // ---- stage 0: event qualification ----
    generate
        if (COUNT_EDGES != 0) begin : g_edge
            logic [CHANNELS-1:0] prev_p1;

            // prev tracks the input every cycle, independent of sample_enable
            always_ff @(posedge sysclk) begin
                if (!sysreset_n)
                    prev_p1 <= '0;
                else
                    prev_p1 <= observable_pulse;
            end

            assign ev_p0 = {CHANNELS{sample_enable}} & observable_pulse & ~prev_p1;
        end else begin : g_level
            assign ev_p0 = {CHANNELS{sample_enable}} & observable_pulse;
        end
    endgenerate

    generate
        if (WINDOW_CYCLES > 0) begin : g_window
            logic [WIN_W-1:0] win_cnt_p1;
            logic             unused_snapshot;

            assign unused_snapshot = snapshot;
            assign snap_ev_p0      = (win_cnt_p1 == WIN_W'(WINDOW_CYCLES - 1));

            always_ff @(posedge sysclk) begin
                if (!sysreset_n || counter_reset)
                    win_cnt_p1 <= '0;
                else if (snap_ev_p0)
                    win_cnt_p1 <= '0;
                else
                    win_cnt_p1 <= win_cnt_p1 + WIN_W'(1);
            end
        end else begin : g_manual
            assign snap_ev_p0 = snapshot;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            live_nxt_p0[i] = next_count(live_p1[i], ev_p0[i]);
    end

    // ---- stage 1: live counters, snapshots, overflow ----
    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live_p1[i] <= '0;
                snap_p1[i] <= '0;
            end
            ovf_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (counter_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live_p1[i] <= '0;
                snap_p1[i] <= '0;
            end
            ovf_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= snap_ev_p0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (snap_ev_p0) begin
                    snap_p1[i] <= live_nxt_p0[i];
                    live_p1[i] <= '0;
                end else begin
                    live_p1[i] <= live_nxt_p0[i];
                end
                if (ev_p0[i] && (live_p1[i] == {WIDTH{1'b1}}))
                    ovf_p1[i] <= 1'b1;
            end
        end
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        sel_data_p1 = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (read_sel == SEL_W'(i))
                sel_data_p1 = snap_p1[i];
    end

    // ---- stage 2: registered readback ----
    always_ff @(posedge sysclk) begin
        if (!sysreset_n)
            cout_p2 <= '0;
        else
            cout_p2 <= sel_data_p1;
    end

    assign counter_out    = cout_p2;
    assign snapshot_valid = vld_p1;
    assign overflow       = ovf_p1;

endmodule

// File: tb/tb_multi_usage_counter.sv
// Self-checking bench for multi_usage_counter: manual, edge-count and windowed instances.
module tb_multi_usage_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Manual-snapshot instance, narrow width for overflow testing
    logic       rstn;
    logic [3:0] m_pulse;
    logic       m_en, m_crst, m_snap;
    logic [2:0] m_sel;
    logic [3:0] m_out;
    logic       m_vld;
    logic [3:0] m_ovf;

    multi_usage_counter #(.CHANNELS(4), .WIDTH(4), .WINDOW_CYCLES(0), .COUNT_EDGES(0), .SEL_W(3)) u_man (
        .sysclk(clk), .sysreset_n(rstn), .observable_pulse(m_pulse), .sample_enable(m_en),
        .counter_reset(m_crst), .snapshot(m_snap), .read_sel(m_sel),
        .counter_out(m_out), .snapshot_valid(m_vld), .overflow(m_ovf));

    // Rising-edge instance
    logic [3:0]  e_pulse;
    logic        e_en, e_crst, e_snap;
    logic [1:0]  e_sel;
    logic [15:0] e_out;
    logic        e_vld;
    logic [3:0]  e_ovf;

    multi_usage_counter #(.CHANNELS(4), .WIDTH(16), .WINDOW_CYCLES(0), .COUNT_EDGES(1)) u_edge (
        .sysclk(clk), .sysreset_n(rstn), .observable_pulse(e_pulse), .sample_enable(e_en),
        .counter_reset(e_crst), .snapshot(e_snap), .read_sel(e_sel),
        .counter_out(e_out), .snapshot_valid(e_vld), .overflow(e_ovf));

    // Windowed instance, W = 10
    logic       w_rstn;
    logic [1:0] w_pulse;
    logic       w_en, w_crst, w_snap;
    logic       w_sel;
    logic [7:0] w_out;
    logic       w_vld;
    logic [1:0] w_ovf;

    multi_usage_counter #(.CHANNELS(2), .WIDTH(8), .WINDOW_CYCLES(10), .COUNT_EDGES(0)) u_win (
        .sysclk(clk), .sysreset_n(w_rstn), .observable_pulse(w_pulse), .sample_enable(w_en),
        .counter_reset(w_crst), .snapshot(w_snap), .read_sel(w_sel),
        .counter_out(w_out), .snapshot_valid(w_vld), .overflow(w_ovf));

    typedef struct {
        logic [2:0] sel;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tbl [5];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] ovf_snap_exp;
`ifdef MULTI_USAGE_COUNTER_SATURATE_EN
        ovf_snap_exp = 4'd15;
`else
        ovf_snap_exp = 4'd4;
`endif
        rd_tbl[0] = '{sel: 3'd0, exp: 4'd5};
        rd_tbl[1] = '{sel: 3'd2, exp: 4'd3};
        rd_tbl[2] = '{sel: 3'd1, exp: 4'd0};
        rd_tbl[3] = '{sel: 3'd7, exp: 4'd0};
        rd_tbl[4] = '{sel: 3'd3, exp: 4'd0};

        rstn = 0; w_rstn = 0;
        m_pulse = '0; m_en = 0; m_crst = 0; m_snap = 0; m_sel = '0;
        e_pulse = '0; e_en = 0; e_crst = 0; e_snap = 0; e_sel = '0;
        w_pulse = '0; w_en = 0; w_crst = 0; w_snap = 0; w_sel = '0;
        cyc(3);

        chk("reset_m_out", m_out, 0);
        chk("reset_m_vld", m_vld, 0);
        chk("reset_m_ovf", m_ovf, 0);
        chk("reset_w_out", w_out, 0);
        chk("reset_w_vld", w_vld, 0);

        // Manual mode: ch0 high 5 enabled cycles, ch2 high 3 of them
        rstn = 1;
        m_en = 1; m_pulse = 4'b0101;
        cyc(3);
        m_pulse = 4'b0001;
        cyc(2);
        m_en = 0; m_pulse = '0; m_snap = 1;
        cyc(1);
        chk("man_vld_pulse", m_vld, 1);
        m_snap = 0;
        cyc(1);
        chk("man_vld_one_cycle", m_vld, 0);
        for (int i = 0; i < 5; i++) begin
            m_sel = rd_tbl[i].sel;
            cyc(1);
            chk($sformatf("man_read_sel%0d", rd_tbl[i].sel), m_out, rd_tbl[i].exp);
        end

        // Overflow: 20 events on ch3 of a 4-bit counter
        m_en = 1; m_pulse = 4'b1000;
        cyc(20);
        m_en = 0; m_pulse = '0; m_snap = 1; m_sel = 3'd3;
        cyc(1);
        m_snap = 0;
        cyc(1);
        chk("ovf_snapshot", m_out, ovf_snap_exp);
        chk("ovf_flags_set", m_ovf, 4'b1000);
        m_crst = 1;
        cyc(1);
        m_crst = 0;
        chk("ovf_cleared", m_ovf, 0);

        // counter_reset beats a coincident snapshot
        m_sel = 3'd0; m_en = 1; m_pulse = 4'b0001;
        cyc(3);
        m_en = 0; m_pulse = '0; m_snap = 1;
        cyc(1);
        m_snap = 0;
        cyc(1);
        chk("crst_pre_snapshot", m_out, 3);
        m_en = 1; m_pulse = 4'b0001;
        cyc(7);
        m_en = 0; m_pulse = '0; m_snap = 1; m_crst = 1;
        cyc(1);
        m_snap = 0; m_crst = 0;
        chk("crst_no_vld", m_vld, 0);
        cyc(1);
        chk("crst_snap_zero", m_out, 0);
        m_snap = 1;
        cyc(1);
        m_snap = 0;
        chk("crst_followup_vld", m_vld, 1);
        cyc(1);
        chk("crst_live_zero", m_out, 0);

        // Back-to-back manual strobes each give a valid pulse
        m_snap = 1;
        cyc(1);
        chk("b2b_vld_first", m_vld, 1);
        cyc(1);
        m_snap = 0;
        chk("b2b_vld_second", m_vld, 1);
        cyc(1);
        chk("b2b_vld_drop", m_vld, 0);

        // Edge counting: ch0 high before enable rises, never counts
        e_pulse[0] = 1;
        for (int i = 0; i < 3; i++) begin
            e_pulse[1] = 1; cyc(1);
            e_pulse[1] = 0; cyc(1);
        end
        e_en = 1;
        for (int i = 0; i < 3; i++) begin
            e_pulse[1] = 1; cyc(1);
            e_pulse[1] = 0; cyc(1);
        end
        e_pulse[2] = 1;
        cyc(4);
        e_en = 0; e_pulse = '0; e_snap = 1;
        cyc(1);
        e_snap = 0;
        chk("edge_vld", e_vld, 1);
        e_sel = 2'd1;
        cyc(1);
        chk("edge_ch1", e_out, 3);
        e_sel = 2'd2;
        cyc(1);
        chk("edge_ch2_held_high", e_out, 1);
        e_sel = 2'd0;
        cyc(1);
        chk("edge_ch0_high_at_enable", e_out, 0);

        // Windowed mode, ch0 tied high
        w_rstn = 1; w_en = 1; w_pulse = 2'b01;
        for (int k = 1; k <= 35; k++) begin
            cyc(1);
            chk($sformatf("win_vld_c%0d", k), w_vld, (k % 10 == 0) ? 1 : 0);
            if (k % 10 == 1 && k > 1)
                chk($sformatf("win_snap_c%0d", k), w_out, 10);
        end

        // Reset mid-window
        w_rstn = 0;
        cyc(1);
        chk("midrst_out", w_out, 0);
        chk("midrst_vld", w_vld, 0);
        chk("midrst_ovf", w_ovf, 0);
        w_rstn = 1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            chk($sformatf("rewin_vld_c%0d", k), w_vld, (k == 10) ? 1 : 0);
            if (k == 11)
                chk("rewin_snap", w_out, 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
